// File: rtl/mixcolumns_pkg.sv
// Shared AES constants and FSM state type for the MixColumns block.
// Holds the GF(2^8) reduction constant, the column geometry and the FSM state type.
package mixcolumns_pkg;
  localparam int NUM_COLS = 4;
  localparam int BYTE_W   = 8;
  localparam int COL_W    = NUM_COLS * BYTE_W;
  localparam int STATE_W  = NUM_COLS * COL_W;

  localparam logic [BYTE_W-1:0] RED_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mixcolumns_col.sv
// Purpose: AES MixColumns transform of one 32-bit column (row 0 = lowest byte).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the output follows the input continuously.
module mixcolumn_col
  import mixcolumns_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? RED_POLY : '0);
  endfunction

  logic [BYTE_W-1:0] a0, a1, a2, a3;
  logic [BYTE_W-1:0] x0, x1, x2, x3;

  assign {a3, a2, a1, a0} = col_in;

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3a is expanded as xtime(a) ^ a
  assign col_out[7:0]   = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_out[15:8]  = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_out[23:16] = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_out[31:24] = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mixcolumns.sv
// Purpose: AES MixColumns over a full 128-bit state, one column per cycle via a shared column unit.
// Latency: 4 cycles from the start edge to done, with state_out complete in that same cycle.
// Backpressure: none; a new start aborts any job in flight and restarts with the new inputs.
module mixcolumns
  import mixcolumns_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               skip,
  input  logic [STATE_W-1:0] state_in,
  output logic [STATE_W-1:0] state_out,
  output logic               done,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [1:0]         col_cnt;
  logic [STATE_W-1:0] state_lat;
  logic               skip_lat;
  logic [COL_W-1:0]   col_cur, col_mix;

  assign col_cur = state_lat[{col_cnt, 5'd0} +: COL_W];

  mixcolumn_col u_col (
    .col_in  (col_cur),
    .col_out (col_mix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // start wins from every state, including the final column edge
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = BUSY;
    end else begin
      case (state_q)
        BUSY:    if (col_cnt == 2'd3) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_out <= '0;
      state_lat <= '0;
      skip_lat  <= 1'b0;
      col_cnt   <= 2'd0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else if (start) begin
      state_lat <= state_in;
      skip_lat  <= skip;
      col_cnt   <= 2'd0;
      state_out <= '0;
      done      <= 1'b0;
      busy      <= 1'b1;
    end else if (state_q == BUSY) begin
      state_out[{col_cnt, 5'd0} +: COL_W] <= skip_lat ? col_cur : col_mix;
      // col_cnt wraps 3->0 on the same edge that enters DONE
      col_cnt <= col_cnt + 2'd1;
      if (col_cnt == 2'd3) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mixcolumns.md
MIXCOLUMNS -- requirements
Module: mixcolumns

Interface
REQ-001 The block SHALL have no parameters; column count (4) and byte width (8) SHALL be fixed constants.
REQ-002 The block SHALL run on one clock and use an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse; state_in and skip are valid in the same cycle.
REQ-006 skip  input  1  sampled with start; 1 = final-round pass-through (no mixing).
REQ-007 state_in  input  128  AES state; byte i = bits [8i+7:8i], row = i mod 4, column = i div 4.
REQ-008 state_out  output  128  result, same byte mapping; registered.
REQ-009 done  output  1  high when state_out holds a complete result; stays high until the next start.
REQ-010 busy  output  1  high while columns are being processed.

Function
REQ-011 On the start edge, state_in and skip SHALL be latched internally, so state_in may change afterwards.
REQ-012 Column c = bits [32c+31:32c]; row 0 = lowest byte.
REQ-013 One column SHALL be processed per cycle, in order 0,1,2,3.
REQ-014 On the start edge (T0): latch inputs, col_cnt<=0, busy<=1, done<=0, state_out<=0.
REQ-015 On edges T1..T4, column col_cnt of state_out SHALL be written; T4 also sets done<=1 and busy<=0.
REQ-016 Latency SHALL be 4 cycles from the start edge to done visible, with state_out complete in the same cycle.
REQ-017 Mixing SHALL use r0'=2a0^3a1^a2^a3, r1'=a0^2a1^3a2^a3, r2'=a0^a1^2a2^3a3, r3'=3a0^a1^a2^2a3.
REQ-018 Multiplication by 2 SHALL use GF(2^8) xtime: shift left, XOR 0x1B if bit 7 was set; 3a = xtime(a)^a.
REQ-019 With skip latched high, each column SHALL be copied unchanged, with identical timing and handshake.
REQ-020 FSM states SHALL be IDLE, BUSY and DONE.
REQ-021 FSM transitions: IDLE-start->BUSY; BUSY-(col_cnt==3)->DONE; DONE-start->BUSY.
REQ-022 start while BUSY SHALL abort the current job and restart per REQ-014 with the new inputs.
REQ-023 A start coinciding with the final (T4) edge SHALL take priority: done stays 0 and the new job begins.
REQ-024 col_cnt SHALL be 2 bits and wrap 3->0 only by returning to DONE; it never writes beyond column 3.
REQ-025 start held high for several cycles SHALL be treated as repeated restarts; only a single pulse is legal use.

Reset
REQ-026 While rst_n is low: state_out=0, done=0, busy=0, col_cnt=0, latched state=0, skip=0, FSM=IDLE.
REQ-027 Reset asserted mid-operation SHALL discard the job immediately; no partial done.
REQ-028 After reset release, the block SHALL remain idle until a start pulse.

Structure
REQ-029 The shared AES package SHALL hold the reduction constant 0x1B, the column count and byte width, and the FSM state typedef.
REQ-030 The single sub-module mixcolumn_col (combinational, 32-bit column in/out, contains xtime) SHALL be instantiated once and time-shared across columns.

Verification
REQ-031 FIPS-197 column: latch a column of 0x455313db (bytes db,13,53,45), skip=0 -> that column of state_out = 0xbca14d8e.
REQ-032 Full state: columns {0x455313db, 0x5c220af2, 0x01010101, 0xd5d4d4d4} -> {0xbca14d8e, 0x9d58dc9f, 0x01010101, 0xd6d7d5d5}; done rises exactly 4 cycles after start.
REQ-033 Same input with skip=1 -> state_out = state_in after 4 cycles; done and busy timing identical to REQ-032.
REQ-034 After start, change state_in on the next cycle -> result matches the originally latched state.
REQ-035 Restart at T2 with a new state -> done only 4 cycles after the second start, with the second result; reset pulsed at T2 -> all outputs 0 and FSM in IDLE.
REQ-036 start on the same edge as T4 -> done stays 0 and the new job completes 4 cycles later.
